spi_int_ctrl: RTL and testbench
===============================

# spi_int_ctrl

Registered interrupt controller for the APB-to-SPI bridge. It samples the four FIFO status flags (TX empty, TX full, RX empty, RX full) and latches them into sticky status bits. Each source can be configured as level or rising-edge. The block gates the status with a per-source enable and drives one registered interrupt line to the host. Software reaches it through the APB register decoder using a simple 2-bit-address register port.

## Interface
- NSRC, 4, number of interrupt sources; bit index 0 tx_empty, 1 tx_full, 2 rx_empty, 3 rx_full
- DW, 8, register data width; bits [DW-1:NSRC] always read 0
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- tx_empty  in  1  TX FIFO empty flag, same clock domain
- tx_full  in  1  TX FIFO full flag
- rx_empty  in  1  RX FIFO empty flag
- rx_full  in  1  RX FIFO full flag
- reg_wr  in  1  register write strobe, one cycle per write
- reg_addr  in  2  register select: 0 ENABLE, 1 STATUS, 2 MODE, 3 RAW
- reg_wdata  in  DW  write data
- reg_rdata  out  DW  combinational read data for reg_addr
- o_int  out  1  registered interrupt, active high

## Operation
- ENABLE (addr 0, RW): per-source interrupt enable. Reset value 0.
- STATUS (addr 1, RW1C): sticky per-source status. Writing 1 to a bit clears it; writing 0 has no effect. Reset value 0.
- MODE (addr 2, RW): per-source trigger mode. 0 means level, 1 means rising-edge. Reset value 0.
- RAW (addr 3, RO): live flag values {rx_full, rx_empty, tx_full, tx_empty}. Writes are ignored.
- flag_q holds the previous-cycle flag vector. While rst is high, flag_q loads the live flags, so a flag that is high when reset deasserts produces no edge event.
- Set condition for bit i:
  - Level mode: flag[i] == 1.
  - Edge mode: flag[i] & ~flag_q[i].
- Status bits set regardless of ENABLE, so software can poll sources that do not raise interrupts.
- Set and W1C clear on the same bit in the same cycle: set wins and the bit stays 1.
- Level source still high after a clear: the bit re-sets on the next edge.
- Changing MODE does not alter STATUS. It only affects set conditions from the next cycle on.
- pending = STATUS & ENABLE.
- o_int is registered: on each clock edge, o_int takes the value of |pending as it was before that edge.
- Reset: ENABLE, STATUS, MODE = 0; o_int = 0; flag_q = live flags.

## Timing
- Flag rise sampled at edge k: STATUS bit is 1 after edge k, and o_int is 1 after edge k+1 (if enabled). Latency from flag to o_int is 2 edges.
- W1C write sampled at edge k (no competing set): STATUS bit is 0 after edge k, and o_int drops after edge k+1.
- ENABLE write at edge k with the status bit already set: o_int asserts after edge k+1. Clearing ENABLE deasserts o_int after edge k+1; STATUS is kept.
- Edge mode:
  - A one-cycle flag pulse sets the bit.
  - A flag held high sets the bit once; after a clear it does not re-set until the flag falls and rises again.
- reg_rdata is combinational from reg_addr and current register state. A read in the same cycle as a write returns the pre-write value.
- rst asserted mid-operation: all state is cleared at the next edge regardless of reg_wr or the flags.

## Structure
- Shared package spi_int_pkg:
  - Address constants ADDR_ENABLE=0, ADDR_STATUS=1, ADDR_MODE=2, ADDR_RAW=3.
  - Source indices SRC_TX_EMPTY=0, SRC_TX_FULL=1, SRC_RX_EMPTY=2, SRC_RX_FULL=3.
  - NSRC.
- Sub-module spi_int_src, instantiated NSRC times. It contains flag_q, the edge/level set logic and the sticky status bit, with inputs flag, mode, clr, rst.
- Top level holds the ENABLE and MODE registers, address decode, read mux and the o_int flop.

## Test plan
- Reset with tx_empty=1, MODE=1 (edge), ENABLE=0x1 -> STATUS=0x0 and o_int=0 for 10 cycles after rst falls.
- MODE=0, ENABLE=0x8, rx_full high at edge k -> STATUS=0x8 after edge k and o_int=1 after edge k+1. W1C 0x8 while rx_full is still high -> STATUS reads 0x8 again one cycle later.
- MODE=0x4, one-cycle rx_empty pulse -> STATUS=0x4. W1C 0x4 -> STATUS=0x0 and stays 0 while rx_empty is held low.
- Edge event on tx_full in the same cycle as a W1C of bit 1 -> STATUS bit 1 remains 1.
- STATUS=0xF, ENABLE=0x0 -> o_int=0. Write ENABLE=0x2 at edge k -> o_int=1 after edge k+1. Write ENABLE=0x0 -> o_int=0 one edge later and STATUS still reads 0xF.
- Write RAW=0xF -> no register changes. Read RAW returns the live flags, and bits [7:4] of every register read as 0.

Source files
------------

// File: rtl/spi_int_ctrl_pkg.sv
// spi_int_pkg: shared constants for the SPI bridge interrupt controller.
//   NSRC / DW     : number of interrupt sources and register data width
//   ADDR_*        : register-port address map
//   SRC_*         : bit index of each FIFO flag inside ENABLE/STATUS/MODE/RAW
package spi_int_pkg;

  localparam int NSRC = 4;
  localparam int DW   = 8;

  localparam logic [1:0] ADDR_ENABLE = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_RAW    = 2'd3;

  localparam int SRC_TX_EMPTY = 0;
  localparam int SRC_TX_FULL  = 1;
  localparam int SRC_RX_EMPTY = 2;
  localparam int SRC_RX_FULL  = 3;

endpackage

// File: rtl/spi_int_ctrl_if.sv
// spi_int_ctrl_if: simple register port between the APB decoder and the
// interrupt controller.
//   reg_wr    : write strobe, one cycle per write
//   reg_addr  : register select
//   reg_wdata : write data
//   reg_rdata : combinational read data for reg_addr
// master = APB decoder side, slave = interrupt controller side.
interface spi_int_ctrl_if #(
  parameter int DW = spi_int_pkg::DW
);

  logic          reg_wr;
  logic [1:0]    reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;

  modport master (output reg_wr, output reg_addr, output reg_wdata, input reg_rdata);
  modport slave  (input reg_wr, input reg_addr, input reg_wdata, output reg_rdata);

endinterface

// File: rtl/spi_int_ctrl_src.sv
// spi_int_src: one interrupt source.
//   clk, rst : clock, synchronous active-high reset
//   flag     : live FIFO flag
//   mode     : 0 = level, 1 = rising-edge trigger
//   clr      : write-1-to-clear strobe for this source
//   status   : sticky status bit
module spi_int_src (
  input  logic clk,
  input  logic rst,
  input  logic flag,
  input  logic mode,
  input  logic clr,
  output logic status
);

  logic flag_q;
  logic status_q;
  logic status_d;
  logic set;

  assign set = mode ? (flag & ~flag_q) : flag;

  // A set in the same cycle as a clear wins.
  always_comb begin
    status_d = status_q;
    if (clr) status_d = 1'b0;
    if (set) status_d = 1'b1;
  end

  // flag_q tracks the live flag in reset too, so a flag already high when
  // reset drops is not seen as a rising edge.
  always_ff @(posedge clk) begin
    flag_q <= flag;
    if (rst) status_q <= 1'b0;
    else     status_q <= status_d;
  end

  assign status = status_q;

endmodule

// File: rtl/spi_int_ctrl.sv
// spi_int_ctrl: registered interrupt controller for the APB-to-SPI bridge.
//   clk, rst                     : clock, synchronous active-high reset
//   tx_empty/tx_full/
//   rx_empty/rx_full             : FIFO status flags (same clock domain)
//   bus (slave)                  : register port; 0 ENABLE, 1 STATUS (W1C),
//                                  2 MODE, 3 RAW (read-only live flags)
//   o_int                        : registered interrupt, |(STATUS & ENABLE)
//                                  delayed by one clock
module spi_int_ctrl #(
  parameter int NSRC = spi_int_pkg::NSRC,
  parameter int DW   = spi_int_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_empty,
  input  logic                 tx_full,
  input  logic                 rx_empty,
  input  logic                 rx_full,
  spi_int_ctrl_if.slave        bus,
  output logic                 o_int
);

  import spi_int_pkg::*;

  logic [NSRC-1:0] flags;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] status;
  logic            int_q, int_d;

  always_comb begin
    flags               = '0;
    flags[SRC_TX_EMPTY] = tx_empty;
    flags[SRC_TX_FULL]  = tx_full;
    flags[SRC_RX_EMPTY] = rx_empty;
    flags[SRC_RX_FULL]  = rx_full;
  end

  // Write decode
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    clr      = '0;
    if (bus.reg_wr) begin
      case (bus.reg_addr)
        ADDR_ENABLE: enable_d = bus.reg_wdata[NSRC-1:0];
        ADDR_STATUS: clr      = bus.reg_wdata[NSRC-1:0];
        ADDR_MODE:   mode_d   = bus.reg_wdata[NSRC-1:0];
        default:     ;
      endcase
    end
  end

  assign int_d = |(status & enable_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      mode_q   <= '0;
      int_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      int_q    <= int_d;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    spi_int_src u_src (
      .clk    (clk),
      .rst    (rst),
      .flag   (flags[i]),
      .mode   (mode_q[i]),
      .clr    (clr[i]),
      .status (status[i])
    );
  end

  // Read mux: reflects current register state, so a same-cycle write is not
  // visible until after the edge.
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      ADDR_ENABLE: bus.reg_rdata[NSRC-1:0] = enable_q;
      ADDR_STATUS: bus.reg_rdata[NSRC-1:0] = status;
      ADDR_MODE:   bus.reg_rdata[NSRC-1:0] = mode_q;
      default:     bus.reg_rdata[NSRC-1:0] = flags;
    endcase
  end

  assign o_int = int_q;

endmodule

// File: tb/tb_spi_int_ctrl.sv
// Self-checking bench for spi_int_ctrl: directed sequences with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural register model.
module tb_spi_int_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] fl;
  logic       o_int;

  spi_int_ctrl_if #(.DW(8)) bus ();

  spi_int_ctrl #(.NSRC(4), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_empty (fl[0]),
    .tx_full  (fl[1]),
    .rx_empty (fl[2]),
    .rx_full  (fl[3]),
    .bus      (bus),
    .o_int    (o_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: register contents as plain bit vectors
  logic [3:0] m_en, m_st, m_md, m_prev;
  logic       m_int;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] setv, clrv;
    logic       nint;
    if (rst) begin
      m_en = 4'h0; m_st = 4'h0; m_md = 4'h0; m_int = 1'b0; m_prev = fl;
    end else begin
      nint = |(m_st & m_en);
      for (int i = 0; i < 4; i++)
        setv[i] = m_md[i] ? (fl[i] && !m_prev[i]) : fl[i];
      clrv = (bus.reg_wr && bus.reg_addr == 2'd1) ? bus.reg_wdata[3:0] : 4'h0;
      m_st = (m_st & ~clrv) | setv;
      if (bus.reg_wr && bus.reg_addr == 2'd0) m_en = bus.reg_wdata[3:0];
      if (bus.reg_wr && bus.reg_addr == 2'd2) m_md = bus.reg_wdata[3:0];
      m_prev = fl;
      m_int  = nint;
    end
    m_valid = 1'b1;
  end

  // Compare process: inputs are stable at the falling edge
  always @(negedge clk) begin
    logic [7:0] exp_rd;
    if (m_valid) begin
      case (bus.reg_addr)
        2'd0:    exp_rd = {4'h0, m_en};
        2'd1:    exp_rd = {4'h0, m_st};
        2'd2:    exp_rd = {4'h0, m_md};
        default: exp_rd = {4'h0, fl};
      endcase
      check("model_rdata", bus.reg_rdata, exp_rd);
      check("model_o_int", {7'h0, o_int}, {7'h0, m_int});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    cyc();
    bus.reg_wr    = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string name);
    bus.reg_wr   = 1'b0;
    bus.reg_addr = a;
    #1;
    check(name, bus.reg_rdata, exp);
  endtask

  task automatic pint(input logic exp, input string name);
    check(name, {7'h0, o_int}, {7'h0, exp});
  endtask

  initial begin
    rst = 1'b1;
    fl  = 4'b0001;
    bus.reg_wr = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = 8'h00;

    // Reset with tx_empty high, then edge mode on tx_empty: no edge appears
    repeat (3) cyc();
    peek(2'd1, 8'h00, "rst_status");
    peek(2'd0, 8'h00, "rst_enable");
    pint(1'b0, "rst_o_int");
    rst = 1'b0;
    wr(2'd2, 8'h01);   // level mode still active at this edge -> bit0 sets
    wr(2'd1, 8'h01);   // now edge mode, flag held -> clear sticks
    wr(2'd0, 8'h01);
    repeat (10) begin
      cyc();
      peek(2'd1, 8'h00, "edge_held_status");
      pint(1'b0, "edge_held_o_int");
    end
    fl = 4'h0;
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h0F);
    peek(2'd1, 8'h00, "cleared");

    // Level rx_full
    wr(2'd0, 8'h08);
    fl = 4'h8;
    cyc();
    peek(2'd1, 8'h08, "lvl_status");
    pint(1'b0, "lvl_o_int_k");
    cyc();
    pint(1'b1, "lvl_o_int_k1");
    wr(2'd1, 8'h08);
    peek(2'd1, 8'h08, "lvl_w1c_reset");
    fl = 4'h0;
    wr(2'd1, 8'h08);
    peek(2'd1, 8'h00, "lvl_w1c_clear");
    pint(1'b1, "lvl_drop_k");
    cyc();
    pint(1'b0, "lvl_drop_k1");
    wr(2'd0, 8'h00);

    // Edge pulse on rx_empty
    wr(2'd2, 8'h04);
    fl = 4'h4;
    cyc();
    fl = 4'h0;
    peek(2'd1, 8'h04, "pulse_status");
    wr(2'd1, 8'h04);
    peek(2'd1, 8'h00, "pulse_clear");
    repeat (3) begin
      cyc();
      peek(2'd1, 8'h00, "pulse_stays_clear");
    end

    // Edge on tx_full coincident with W1C of bit 1
    wr(2'd2, 8'h02);
    fl = 4'h2;
    wr(2'd1, 8'h02);
    peek(2'd1, 8'h02, "set_beats_clear");
    wr(2'd1, 8'h02);
    peek(2'd1, 8'h00, "held_edge_clear");
    cyc();
    peek(2'd1, 8'h00, "held_edge_no_reset");
    fl = 4'h0;

    // ENABLE gating
    wr(2'd2, 8'h00);
    fl = 4'hF;
    cyc();
    fl = 4'h0;
    peek(2'd1, 8'h0F, "all_status");
    cyc();
    pint(1'b0, "disabled_o_int");
    wr(2'd0, 8'h02);
    pint(1'b0, "en_o_int_k");
    cyc();
    pint(1'b1, "en_o_int_k1");
    wr(2'd0, 8'h00);
    pint(1'b1, "dis_o_int_k");
    cyc();
    pint(1'b0, "dis_o_int_k1");
    peek(2'd1, 8'h0F, "dis_keeps_status");

    // RAW is read-only, upper bits read zero
    fl = 4'h5;
    wr(2'd3, 8'hFF);
    peek(2'd0, 8'h00, "raw_wr_enable");
    peek(2'd1, 8'h0F, "raw_wr_status");
    peek(2'd2, 8'h00, "raw_wr_mode");
    peek(2'd3, 8'h05, "raw_read");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 4) == 0) fl[b] = ~fl[b];
      rst           = ($urandom_range(0, 149) == 0);
      bus.reg_wr    = ($urandom_range(0, 2) == 0);
      bus.reg_addr  = 2'($urandom);
      bus.reg_wdata = 8'($urandom);
      cyc();
    end
    rst = 1'b0;
    bus.reg_wr = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
